// File: rtl/fpu_compare_unit_if.sv
// Request/result bundle between FPU_Core and fpu_compare_unit.
// The master drives the request; the slave (compare unit) returns status and condition codes.
interface fpu_compare_unit_if #(
    parameter int EXP_W  = 15,
    parameter int MANT_W = 64
);
    logic                  start;
    logic [1:0]            op;
    logic [EXP_W+MANT_W:0] operand_a;
    logic [EXP_W+MANT_W:0] operand_b;
    logic                  busy;
    logic                  done;
    logic                  cc_c3;
    logic                  cc_c2;
    logic                  cc_c1;
    logic                  cc_c0;
    logic                  invalid;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, cc_c3, cc_c2, cc_c1, cc_c0, invalid
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, cc_c3, cc_c2, cc_c1, cc_c0, invalid
    );
endinterface

// File: rtl/fpu_compare_unit.sv
// Multi-cycle x87 compare/classify engine (FCOM, FUCOM, FTST, optional FXAM) producing C3..C0 and IE.
// FXAM classification is built only when FPU_COMPARE_FXAM_EN is defined.
module fpu_compare_unit #(
    parameter int EXP_W   = 15,
    parameter int MANT_W  = 64,
    parameter int CHUNK_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fpu_compare_unit_if.slave  bus
);
    localparam int N     = MANT_W / CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_FUCOM = 2'b01;
    localparam logic [1:0] OP_FTST  = 2'b10;
    localparam logic [1:0] OP_FXAM  = 2'b11;

    // {C3, C2, C0}
    localparam logic [2:0] R_GT = 3'b000;
    localparam logic [2:0] R_LT = 3'b001;
    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_UN = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CLASSIFY, S_MANT, S_DONE} state_t;

    typedef struct packed {
        logic zero;
        logic denorm;
        logic inf;
        logic nan;
        logic snan;
        logic uns;
    } cls_t;

    state_t              r_state, w_next;
    logic [1:0]          r_op;
    logic [IDX_W-1:0]    r_idx;
    logic                r_sa, r_sb;
    logic [EXP_W-1:0]    r_ea, r_eb;
    logic [MANT_W-1:0]   r_ma, r_mb;
    logic                r_c3, r_c2, r_c1, r_c0, r_inv;

    cls_t                w_ca, w_cb;
    logic [CHUNK_W-1:0]  w_ch_a, w_ch_b;
    logic                w_set;
    logic [2:0]          w_res;
    logic                w_res_c1;
    logic                w_res_inv;
    logic                w_unused;

    function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
        cls_t c;
        logic e_zero, e_max, frac_nz;
        e_zero   = ~|e;
        e_max    = &e;
        frac_nz  = |m[MANT_W-2:0];
        c.zero   = e_zero & ~|m;
        c.denorm = e_zero & |m;
        c.inf    = e_max & m[MANT_W-1] & ~frac_nz;
        c.nan    = e_max & m[MANT_W-1] & frac_nz;
        c.snan   = c.nan & ~m[MANT_W-2];
        c.uns    = ~e_zero & ~m[MANT_W-1];
        return c;
    endfunction

    // Magnitude order, flipped when both operands are negative.
    function automatic logic [2:0] order(input logic a_gt, input logic both_neg);
        return (a_gt ^ both_neg) ? R_GT : R_LT;
    endfunction

    assign w_ca     = classify(r_ea, r_ma);
    assign w_cb     = classify(r_eb, r_mb);
    assign w_ch_a   = CHUNK_W'(r_ma >> (CHUNK_W * (N - 1 - int'(r_idx))));
    assign w_ch_b   = CHUNK_W'(r_mb >> (CHUNK_W * (N - 1 - int'(r_idx))));
    assign w_unused = ^{w_ca.inf, w_ca.denorm, w_cb.inf, w_cb.denorm};

    always_comb begin
        w_next    = r_state;
        w_set     = 1'b0;
        w_res     = R_UN;
        w_res_c1  = 1'b0;
        w_res_inv = 1'b0;
        unique case (r_state)
            S_IDLE: if (bus.start) w_next = S_CLASSIFY;
            S_CLASSIFY: begin
                w_next = S_DONE;
                w_set  = 1'b1;
                if (r_op == OP_FXAM) begin
`ifdef FPU_COMPARE_FXAM_EN
                    w_res_c1 = r_sa;
                    if (w_ca.uns)         w_res = 3'b000;
                    else if (w_ca.nan)    w_res = 3'b001;
                    else if (w_ca.inf)    w_res = 3'b011;
                    else if (w_ca.zero)   w_res = 3'b100;
                    else if (w_ca.denorm) w_res = 3'b110;
                    else                  w_res = 3'b010;
`else
                    w_res_inv = 1'b1;
`endif
                end else if (w_ca.nan | w_ca.uns | w_cb.nan | w_cb.uns) begin
                    w_res_inv = (r_op != OP_FUCOM) | w_ca.snan | w_ca.uns | w_cb.snan | w_cb.uns;
                end else if (w_ca.zero & w_cb.zero) begin
                    w_res = R_EQ;
                end else if (r_sa != r_sb) begin
                    w_res = r_sa ? R_LT : R_GT;
                end else if (r_ea != r_eb) begin
                    w_res = order(r_ea > r_eb, r_sa);
                end else begin
                    w_next = S_MANT;
                    w_set  = 1'b0;
                end
            end
            S_MANT: begin
                if (w_ch_a != w_ch_b) begin
                    w_next = S_DONE;
                    w_set  = 1'b1;
                    w_res  = order(w_ch_a > w_ch_b, r_sa);
                end else if (r_idx == IDX_W'(N - 1)) begin
                    w_next = S_DONE;
                    w_set  = 1'b1;
                    w_res  = R_EQ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_idx   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_ea    <= '0;
            r_eb    <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_c3    <= 1'b0;
            r_c2    <= 1'b0;
            r_c1    <= 1'b0;
            r_c0    <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_op               <= bus.op;
                r_idx              <= '0;
                {r_sa, r_ea, r_ma} <= bus.operand_a;
                // FTST compares against +0 regardless of operand_b.
                {r_sb, r_eb, r_mb} <= (bus.op == OP_FTST) ? '0 : bus.operand_b;
            end
            if (r_state == S_MANT) r_idx <= r_idx + 1'b1;
            if (w_set) begin
                r_c3  <= w_res[2];
                r_c2  <= w_res[1];
                r_c0  <= w_res[0];
                r_c1  <= w_res_c1;
                r_inv <= w_res_inv;
            end
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.cc_c3   = r_c3;
    assign bus.cc_c2   = r_c2;
    assign bus.cc_c1   = r_c1;
    assign bus.cc_c0   = r_c0;
    assign bus.invalid = r_inv;
endmodule

// File: tb/tb_fpu_compare_unit.sv
// Randomized self-checking bench for fpu_compare_unit against a value-level reference model.
// Define FPU_COMPARE_FXAM_EN for both bench and RTL to cover FXAM.
module tb_fpu_compare_unit;
    localparam int EW = 15;
    localparam int MW = 64;
    localparam int CW = 16;
    localparam int NC = MW / CW;
    localparam int W  = 1 + EW + MW;

    localparam int K_ZERO = 0, K_DEN = 1, K_INF = 2, K_QNAN = 3, K_SNAN = 4, K_UNS = 5, K_NORM = 6;

    localparam logic [W-1:0] P1     = 80'h3FFF_8000_0000_0000_0000;
    localparam logic [W-1:0] P15    = 80'h3FFF_C000_0000_0000_0000;
    localparam logic [W-1:0] P2     = 80'h4000_8000_0000_0000_0000;
    localparam logic [W-1:0] N1     = 80'hBFFF_8000_0000_0000_0000;
    localparam logic [W-1:0] N15    = 80'hBFFF_C000_0000_0000_0000;
    localparam logic [W-1:0] PLSB   = 80'h3FFF_8000_0000_0000_0001;
    localparam logic [W-1:0] PZ     = 80'h0000_0000_0000_0000_0000;
    localparam logic [W-1:0] NZ     = 80'h8000_0000_0000_0000_0000;
    localparam logic [W-1:0] QNAN   = 80'h7FFF_C000_0000_0000_0000;
    localparam logic [W-1:0] SNAN   = 80'h7FFF_A000_0000_0000_0000;
    localparam logic [W-1:0] NINF   = 80'hFFFF_8000_0000_0000_0000;

    typedef struct {
        logic [2:0] ccc;   // {C3, C2, C0}
        logic       c1;
        logic       inv;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t cur;
    bit   pend = 0;
    bit   mon_en = 0;
    int   cyc = 0;
    logic [4:0] held = '0;  // {C3, C2, C1, C0, IE} last delivered result

    fpu_compare_unit_if #(.EXP_W(EW), .MANT_W(MW)) bus ();

    fpu_compare_unit #(.EXP_W(EW), .MANT_W(MW), .CHUNK_W(CW)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int kind(input logic [W-1:0] x);
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        e = x[W-2:MW];
        m = x[MW-1:0];
        if (e == '0) return (m == '0) ? K_ZERO : K_DEN;
        if (!m[MW-1]) return K_UNS;
        if (e == '1) begin
            if (m[MW-2:0] == '0) return K_INF;
            return m[MW-2] ? K_QNAN : K_SNAN;
        end
        return K_NORM;
    endfunction

    function automatic bit unord(input int k);
        return (k == K_QNAN) || (k == K_SNAN) || (k == K_UNS);
    endfunction

    // Value-level reference: finite operands order by sign then unsigned {exp, mant}.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] bi);
        exp_t r;
        logic [W-1:0] b;
        logic [MW-1:0] diff;
        int ka, kb;
        logic gt;
        r.ccc = 3'b111;
        r.c1  = 1'b0;
        r.inv = 1'b0;
        r.lat = 2;
        b  = (op == 2'b10) ? '0 : bi;
        ka = kind(a);
        kb = kind(b);
        if (op == 2'b11) begin
`ifdef FPU_COMPARE_FXAM_EN
            r.c1 = a[W-1];
            case (ka)
                K_UNS:          r.ccc = 3'b000;
                K_QNAN, K_SNAN: r.ccc = 3'b001;
                K_NORM:         r.ccc = 3'b010;
                K_INF:          r.ccc = 3'b011;
                K_ZERO:         r.ccc = 3'b100;
                default:        r.ccc = 3'b110;
            endcase
`else
            r.inv = 1'b1;
`endif
            return r;
        end
        if (unord(ka) || unord(kb)) begin
            r.inv = (op != 2'b01) || ka == K_SNAN || ka == K_UNS || kb == K_SNAN || kb == K_UNS;
            return r;
        end
        if (ka == K_ZERO && kb == K_ZERO) begin
            r.ccc = 3'b100;
            return r;
        end
        if (a[W-1] != b[W-1]) begin
            r.ccc = a[W-1] ? 3'b001 : 3'b000;
            return r;
        end
        if (a[W-2:MW] == b[W-2:MW]) begin
            diff  = a[MW-1:0] ^ b[MW-1:0];
            r.lat = 2 + NC;
            for (int p = 0; p < MW; p++)
                if (diff[p]) r.lat = 2 + (MW - 1 - p) / CW + 1;
        end
        gt = a[W-2:0] > b[W-2:0];
        if (a[W-2:0] == b[W-2:0]) r.ccc = 3'b100;
        else                      r.ccc = (gt ^ a[W-1]) ? 3'b000 : 3'b001;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        s = 1'($urandom);
        case ($urandom_range(0, 5))
            0:       e = '0;
            1:       e = '1;
            2:       e = 15'h3FFF;
            3:       e = 15'h3FFE;
            default: e = EW'($urandom);
        endcase
        case ($urandom_range(0, 6))
            0:       m = '0;
            1:       m = 64'h8000_0000_0000_0000;
            2:       m = 64'hC000_0000_0000_0000;
            3:       m = 64'hA000_0000_0000_0000;
            4:       m = {1'b0, 63'({$urandom, $urandom})};
            default: m = {1'b1, 63'({$urandom, $urandom})};
        endcase
        return {s, e, m};
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (pend) begin
                cyc++;
                chk("busy_active", bus.busy, 1);
                if (bus.done) begin
                    chk("latency", cyc, cur.lat);
                    chk("c3c2c0", {bus.cc_c3, bus.cc_c2, bus.cc_c0}, cur.ccc);
                    chk("c1", bus.cc_c1, cur.c1);
                    chk("invalid", bus.invalid, cur.inv);
                    held = {cur.ccc[2], cur.ccc[1], cur.c1, cur.ccc[0], cur.inv};
                    pend = 0;
                end else if (cyc >= cur.lat + 8) begin
                    chk("done_timeout", 0, 1);
                    pend = 0;
                end
            end else begin
                chk("idle_done", bus.done, 0);
                chk("idle_busy", bus.busy, 0);
                chk("held", {bus.cc_c3, bus.cc_c2, bus.cc_c1, bus.cc_c0, bus.invalid}, held);
            end
        end
    end

    task automatic wait_idle();
        for (int t = 0; t < 40 && pend; t++) begin
            @(negedge clk);
            #1;
        end
        if (pend) begin
            chk("wait_idle", 0, 1);
            pend = 0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.op        = 2'($urandom);
        bus.operand_a = W'({$urandom, $urandom, $urandom});
        bus.operand_b = W'({$urandom, $urandom, $urandom});
        cur  = model(op, a, b);
        cyc  = 0;
        pend = 1;
    endtask

    task automatic pin(input string nm, input exp_t e, input logic [4:0] want, input int lat);
        chk(nm, {e.ccc, e.c1, e.inv}, want);
        chk(nm, e.lat, lat);
    endtask

    initial begin
        logic [W-1:0] a, b;
        bus.start     = 1'b0;
        bus.op        = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out", {bus.cc_c3, bus.cc_c2, bus.cc_c1, bus.cc_c0, bus.invalid}, 0);
        rst    = 1'b0;
        mon_en = 1;

        // Hand-computed anchors for the reference model ({C3,C2,C0}, C1, IE).
        pin("pin_gt",       model(2'b00, P2, P1),    5'b000_0_0, 2);
        pin("pin_lt_chunk", model(2'b00, P1, P15),   5'b001_0_0, 3);
        pin("pin_negswap",  model(2'b00, N1, N15),   5'b000_0_0, 3);
        pin("pin_eq_full",  model(2'b00, PLSB, PLSB), 5'b100_0_0, 6);
        pin("pin_zero",     model(2'b00, PZ, NZ),    5'b100_0_0, 2);
        pin("pin_fucom_q",  model(2'b01, QNAN, P1),  5'b111_0_0, 2);
        pin("pin_fcom_q",   model(2'b00, QNAN, P1),  5'b111_0_1, 2);
        pin("pin_fucom_s",  model(2'b01, SNAN, P1),  5'b111_0_1, 2);
        pin("pin_ftst",     model(2'b10, N1, P2),    5'b001_0_0, 2);
`ifdef FPU_COMPARE_FXAM_EN
        pin("pin_fxam",     model(2'b11, NINF, P1),  5'b011_1_0, 2);
`else
        pin("pin_fxam_off", model(2'b11, NINF, P1),  5'b111_0_1, 2);
`endif

        issue(2'b00, P2, P1);
        issue(2'b00, P1, P15);
        issue(2'b00, N1, N15);
        issue(2'b00, PLSB, PLSB);
        issue(2'b00, PZ, NZ);
        issue(2'b01, QNAN, P1);
        issue(2'b00, QNAN, P1);
        issue(2'b01, SNAN, P1);

        // FTST with a second start pulsed while busy; it must be dropped.
        issue(2'b10, N1, P2);
        @(negedge clk);
        #1;
        bus.op        = 2'b00;
        bus.operand_a = P2;
        bus.operand_b = P1;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // Abort a full-length mantissa compare in cycle 4.
        issue(2'b00, PLSB, PLSB);
        for (int t = 0; t < 10 && cyc < 4; t++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_cycle", cyc, 4);
        rst  = 1'b1;
        pend = 0;
        held = '0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_out", {bus.cc_c3, bus.cc_c2, bus.cc_c1, bus.cc_c0, bus.invalid}, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);

`ifdef FPU_COMPARE_FXAM_EN
        issue(2'b11, NINF, P1);
`endif
        issue(2'b11, PZ, P1);

        for (int i = 0; i < 300; i++) begin
            a = rnd_op();
            case ($urandom_range(0, 3))
                0:       b = rnd_op();
                1:       b = a;
                2:       b = a ^ (W'(1) << $urandom_range(0, MW - 1));
                default: b = a ^ {1'b1, {(W-1){1'b0}}};
            endcase
            issue(2'($urandom_range(0, 3)), a, b);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_compare_unit.md
# fpu_compare_unit

Parametrised multi-cycle floating-point compare/classify engine for the 8087 FPU datapath, the successor to the single-purpose FCOM path inside `FPU_Core`. It accepts two operands in extended-precision-style layout (sign | biased exponent | explicit-integer mantissa) of configurable width. It executes FCOM, FUCOM, FTST and, optionally, FXAM. Results are the x87 condition codes C3/C2/C1/C0 plus an invalid-operation flag. `FPU_Core` starts it from STATE_EXECUTE and waits on `done` before writeback.

## Interface
- `EXP_W`, default 15: exponent width.
- `MANT_W`, default 64: mantissa width, including the explicit integer bit at `MANT_W-1`.
- `CHUNK_W`, default 16: mantissa bits compared per cycle. Must divide `MANT_W`. `N = MANT_W/CHUNK_W`.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin operation. Sampled only in IDLE.
- `op`, in, 2: operation select. 00 = FCOM, 01 = FUCOM, 10 = FTST, 11 = FXAM.
- `operand_a`, in, `1+EXP_W+MANT_W`: ST(0).
- `operand_b`, in, `1+EXP_W+MANT_W`: ST(i) or memory operand. Ignored for FTST and FXAM.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done`, out, 1: one-cycle pulse; results are valid from this cycle on.
- `cc_c3`, `cc_c2`, `cc_c1`, `cc_c0`, out, 1 each: condition codes. Held until the next `done`.
- `invalid`, out, 1: IE exception for the completed operation. Held with the condition codes.

## Operation
- States: IDLE → CLASSIFY → (MANT) → DONE → IDLE.
- **IDLE**
  - When `start=1`, latch `operand_a`, `operand_b` and `op`; go to CLASSIFY.
  - For FTST, the latched B is +0.
- **CLASSIFY** (1 cycle). Per operand, classify as:
  - zero: exp = 0, mant = 0
  - denormal: exp = 0, mant ≠ 0
  - inf: exp all-ones, mant = 1000…0
  - NaN: exp all-ones, fraction ≠ 0, integer bit = 1
    - SNaN: NaN with mant[MANT_W-2] = 0
    - QNaN: otherwise
  - unsupported: exp ≠ 0 with integer bit = 0
  - normal: everything else
- **Compare decision order** (first match wins):
  1. Any NaN or unsupported operand → unordered (C3 C2 C0 = 111).
     - FCOM/FTST: `invalid=1`.
     - FUCOM: `invalid=1` only for SNaN or unsupported.
  2. Both zero → equal, regardless of sign.
  3. Signs differ → negative operand is less.
  4. Exponents differ → larger exponent has the larger magnitude.
  5. Otherwise go to MANT.
- Result is the magnitude result, inverted when both operands are negative. Denormals compare as finite values by unsigned {exp, mant}.
- **MANT**
  - Counter `idx` runs 0..N-1 and compares chunk `MANT_W-1-idx*CHUNK_W` downward, MSB first.
  - First unequal chunk decides the result and moves to DONE.
  - All N chunks equal → equal.
- **Encoding:** A > B = 000; A < B: C0 = 1; equal: C3 = 1; unordered: 111. C1 = 0 for all compares.
- **DONE:** update outputs, pulse `done`, return to IDLE.
- `start` while `busy=1` is ignored; no queueing.

## Timing
- Reset values: `busy`, `done`, all `cc_*` and `invalid` are 0; state is IDLE; `idx` is 0.
- `start` accepted at edge 0 → CLASSIFY at edge 1.
- Early decision: `done` is high in cycle 2.
- Mantissa path: `done` is high in cycle 2+k, where k (1..N) is the number of chunks examined. Worst case is 2+N = 6 with default parameters.
- `start` may be reasserted in the cycle `done` is high. It is accepted at the next edge, when the FSM is in IDLE.
- Reset mid-operation aborts immediately. No `done`. Outputs return to reset values.
- Operand inputs may change after the accept edge without effect.

## Configuration
- `FPU_COMPARE_FXAM_EN` defined: `op=11` performs FXAM on A with latency 2.
  - C1 = sign of A.
  - C3 C2 C0: unsupported 000, NaN 001, normal 010, inf 011, zero 100, denormal 110.
  - `invalid` = 0.
- Macro undefined: `op=11` completes with latency 2 as unordered (111), C1 = 0, `invalid=1`. No classify-output logic is synthesised.

## Test plan
- FCOM A = 0x4000_8000000000000000 (2.0), B = 0x3FFF_8000000000000000 (1.0) → C3 C2 C0 = 000, `invalid=0`, `done` in cycle 2.
- FCOM A = 1.0, B = 0x3FFF_C000000000000000 (1.5) → C0 = 1, `done` in cycle 3. Swap the operand signs (both negative) → 000.
- FCOM A = B = 0x3FFF_8000000000000001 → C3 = 1, `done` in cycle 6. Also +0 vs 0x8000_0…0 (−0) → C3 = 1, latency 2.
- FUCOM QNaN 0x7FFF_C000000000000000 vs 1.0 → 111, `invalid=0`. Same operands with FCOM → `invalid=1`. FUCOM SNaN 0x7FFF_A000000000000000 → `invalid=1`.
- FTST A = 0xBFFF_8000000000000000 (−1.0) → C0 = 1. Pulse `start` again while `busy` → ignored: exactly one `done`, and outputs are unchanged by the second request.
- Assert `reset` in MANT cycle 4 → no `done`, all outputs 0. With `FPU_COMPARE_FXAM_EN`, FXAM on 0xFFFF_8000000000000000 (−inf) → C1 = 1, C3 C2 C0 = 011.
